cacheline_adaptor: RTL
======================

// Module: cacheline_adaptor
// PURPOSE
//   Bridges the cache's 256-bit line interface to the burst-mode main memory (4 beats x 64 bits).
//   Sits between the cache's memory-side port and the burst memory model driven by the top-level bench.
//   Serialises line writebacks into bursts and deserialises read bursts into full lines.
//   One transaction at a time; fully registered outputs.
// PARAMETERS
//   LINE_W          256   cache line width in bits
//   BURST_W         64    memory beat width in bits; BEATS = LINE_W/BURST_W (=4), must be an integer >= 2
//   ADDR_W          32    address width
//   TIMEOUT_CYCLES  1024  max wait cycles per beat (used only with the macro below)
// PORTS
//   clk        in   1        system clock, all state updates on posedge
//   rst        in   1        asynchronous, active-high reset
//   line_i     in   LINE_W   writeback line from cache, sampled when write_i is accepted
//   line_o     out  LINE_W   assembled read line, valid while resp_o=1, held until the next read completes
//   address_i  in   ADDR_W   cache request address
//   read_i     in   1        cache line-read request (level; accepted only in IDLE)
//   write_i    in   1        cache line-write request (level; accepted only in IDLE)
//   resp_o     out  1        one-cycle completion pulse to cache
//   burst_i    in   BURST_W  read beat from memory, valid when resp_i=1
//   burst_o    out  BURST_W  write beat to memory
//   address_o  out  ADDR_W   line-aligned memory address {address_i[ADDR_W-1:5],5'b0}
//   read_o     out  1        memory burst-read request
//   write_o    out  1        memory burst-write request
//   resp_i     in   1        memory beat strobe (one beat transferred per cycle resp_i=1)
//   err_o      out  1        sticky timeout flag (present only with CACHELINE_ADAPTOR_TIMEOUT_EN)
// BEHAVIOUR
//   Reset: state=IDLE, beat counter=0, line_o=0, burst_o=0, address_o=0, read_o=write_o=resp_o=0, err_o=0.
//   FSM: IDLE -> RD (read_i) | WR (write_i); RD/WR -> DONE after beat BEATS-1; DONE -> IDLE unconditionally.
//   IDLE: write_i has priority if read_i and write_i are both high. On acceptance at edge N, latch address
//     (line-aligned) and, for writes, line_i. read_o/write_o rise at N+1. resp_i in IDLE is ignored.
//   RD: each cycle with resp_i=1 stores burst_i into line slot [cnt*BURST_W +: BURST_W], cnt++.
//     Beats may be non-consecutive; cycles with resp_i=0 are waits. read_o drops at the edge capturing the last beat.
//   WR: burst_o = latched line slot cnt, registered so it is valid at the first cycle write_o=1. Each resp_i=1
//     advances cnt and burst_o to the next slot. write_o drops at the edge of the last beat.
//   DONE: resp_o=1 for exactly one cycle (one cycle after the last beat). line_o updated by then.
//   read_i/write_i are ignored in RD/WR/DONE; the cache must deassert them on seeing resp_o.
//     A request still high in the IDLE cycle after DONE is treated as new.
//   Counter: log2(BEATS) bits, wraps to 0 on the last beat. Never exceeds BEATS-1.
//   Latency with zero-wait memory: request edge N, beats N+1..N+4, resp_o in cycle N+5.
//   Asynchronous reset mid-burst: immediate return to IDLE, all outputs to reset values, partial line discarded.
// CONFIGURATION
//   CACHELINE_ADAPTOR_TIMEOUT_EN defined: a wait counter clears on every beat and on entry to RD/WR.
//     If it reaches TIMEOUT_CYCLES in RD/WR, err_o sets (sticky until rst), read_o/write_o drop, and the FSM
//     goes to DONE (resp_o pulses, line_o holds partial data).
//   Not defined: no err_o port, no counter, and the adaptor waits indefinitely for resp_i.
// TESTING
//   Read, resp_i on 4 consecutive cycles, beats 0x11..,0x22..,0x33..,0x44.. -> line_o={0x44..,0x33..,0x22..,0x11..},
//     resp_o 1 cycle, address_i=0x1234_5678 -> address_o=0x1234_5660.
//   Write line 0xDDDD..CCCC..BBBB..AAAA with resp_i having 2 idle gaps -> burst_o AAAA,BBBB,CCCC,DDDD in order,
//     each held until its resp_i, write_o low after beat 3.
//   read_i and write_i high together in IDLE -> write burst performed, read_o never asserts.
//   rst pulsed after beat 2 of a read -> all outputs 0 at once; a following read returns a clean full line.
//   Back-to-back: read_i held through resp_o -> second read starts the cycle after IDLE; spurious resp_i in IDLE ignored.
//   With CACHELINE_ADAPTOR_TIMEOUT_EN, TIMEOUT_CYCLES=8, no resp_i -> err_o=1 and resp_o pulse after 8 wait cycles.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//   Bridges a cache's full-line memory port to a burst-mode main memory.
//   A line writeback is serialised into BEATS beats of BURST_W bits, and a
//   read burst is deserialised back into one full line. Only one transaction
//   is in flight at a time, and every output is driven straight from a flop.
//
//   Optional feature: define CACHELINE_ADAPTOR_TIMEOUT_EN to add a per-beat
//   wait counter, the TIMEOUT_CYCLES parameter and the sticky err_o port.
//   Without the macro the adaptor waits indefinitely for resp_i.
//
// Ports
//   clk        in   system clock, all state updates on posedge
//   rst        in   asynchronous active-high reset
//   line_i     in   writeback line, captured when a write is accepted
//   line_o     out  assembled read line, held until the next read completes
//   address_i  in   cache request address
//   read_i     in   line-read request (level, looked at only in IDLE)
//   write_i    in   line-write request (level, looked at only in IDLE, wins over read_i)
//   resp_o     out  one-cycle completion pulse to the cache
//   burst_i    in   read beat from memory, valid when resp_i=1
//   burst_o    out  write beat to memory
//   address_o  out  line-aligned memory address
//   read_o     out  memory burst-read request
//   write_o    out  memory burst-write request
//   resp_i     in   memory beat strobe, one beat per cycle it is high
//   err_o      out  sticky timeout flag (only with CACHELINE_ADAPTOR_TIMEOUT_EN)
//
// LINE_W/BURST_W must be an integer of at least 2.
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    ,
    output logic               err_o
`endif
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    // Clears the byte-offset-within-line bits of the request address.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_W / 8 - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Line viewed as beat slots; slot 0 occupies the least significant bits.
    typedef logic [BEATS-1:0][BURST_W-1:0] line_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    line_t            wline_q;
    line_t            rline_q;
    line_t            rline_d;
    logic             busy_s;
    logic             last_beat_s;
    logic             timeout_s;

    // Next beat index and the read buffer with the current beat merged in.
    always_comb begin
        busy_s      = (state_q == S_RD) || (state_q == S_WR);
        last_beat_s = busy_s && resp_i && (cnt_q == LAST_BEAT);
        rline_d     = rline_q;
        if (last_beat_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((state_q == S_RD) && resp_i) begin
            rline_d[cnt_q] = burst_i;
        end else begin
            rline_d = rline_q;
        end
    end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q;

    // Fires on the wait cycle that would bring the counter to TIMEOUT_CYCLES;
    // a beat in the same cycle always wins.
    assign timeout_s = busy_s && !resp_i &&
                       (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Per-beat wait counter (cleared outside RD/WR, so also on entry) and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= {WAIT_W{1'b0}};
            err_o  <= 1'b0;
        end else begin
            if (!busy_s || resp_i || timeout_s) begin
                wait_q <= {WAIT_W{1'b0}};
            end else begin
                wait_q <= wait_q + WAIT_W'(1);
            end
            if (timeout_s) begin
                err_o <= 1'b1;
            end else begin
                err_o <= err_o;
            end
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Transaction FSM together with all registered outputs and line buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            wline_q   <= {LINE_W{1'b0}};
            rline_q   <= {LINE_W{1'b0}};
            line_o    <= {LINE_W{1'b0}};
            burst_o   <= {BURST_W{1'b0}};
            address_o <= {ADDR_W{1'b0}};
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (write_i) begin
                        // Slot 0 is presented together with the rising write_o.
                        address_o <= address_i & LINE_MASK;
                        wline_q   <= line_i;
                        burst_o   <= line_i[BURST_W-1:0];
                        write_o   <= 1'b1;
                        state_q   <= S_WR;
                    end else if (read_i) begin
                        // Start from a clean buffer so a timed-out read never shows stale beats.
                        address_o <= address_i & LINE_MASK;
                        rline_q   <= {LINE_W{1'b0}};
                        read_o    <= 1'b1;
                        state_q   <= S_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (resp_i) begin
                        rline_q <= rline_d;
                        cnt_q   <= cnt_d;
                        if (last_beat_s) begin
                            line_o  <= rline_d;
                            read_o  <= 1'b0;
                            resp_o  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RD;
                        end
                    end else if (timeout_s) begin
                        line_o  <= rline_q;
                        read_o  <= 1'b0;
                        resp_o  <= 1'b1;
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_RD;
                    end
                end
                S_WR: begin
                    if (resp_i) begin
                        cnt_q   <= cnt_d;
                        burst_o <= wline_q[cnt_d];
                        if (last_beat_s) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WR;
                        end
                    end else if (timeout_s) begin
                        write_o <= 1'b0;
                        resp_o  <= 1'b1;
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WR;
                    end
                end
                S_DONE: begin
                    cnt_q   <= {CNT_W{1'b0}};
                    state_q <= S_IDLE;
                end
                default: begin
                    cnt_q   <= {CNT_W{1'b0}};
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
